// File: rtl/nap_slave_responder_if.sv
// AXI4 channel bundle between a NoC master and the fabric-side slave responder.
interface t_AXI4 #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 28,
    parameter int ID_WIDTH   = 8
);
    localparam int BPB = DATA_WIDTH / 8;

    logic [ID_WIDTH-1:0]   awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [BPB-1:0]        wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [ID_WIDTH-1:0]   bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    logic [ID_WIDTH-1:0]   arid;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  arvalid;
    logic                  arready;

    logic [ID_WIDTH-1:0]   rid;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bid, bresp, bvalid, output bready,
        output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
        input rid, rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bid, bresp, bvalid, input bready,
        input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/nap_slave_responder.sv
// AXI4 slave responder backed by a byte-lane simple-dual-port memory.
// Define NAP_SLAVE_RESPONDER_STATS_EN to build the completed-burst counters.
module nap_slave_responder #(
    parameter int DATA_WIDTH     = 256,
    parameter int ADDR_WIDTH     = 28,
    parameter int ID_WIDTH       = 8,
    parameter int MEM_DEPTH_LOG2 = 9
) (
    input  logic        i_clk,
    input  logic        i_reset,
    t_AXI4.slave        nap,
    output logic        o_error_valid,
    output logic [2:0]  o_error_info,
    output logic [31:0] o_wr_bursts,
    output logic [31:0] o_rd_bursts
);
    localparam int BPB  = DATA_WIDTH / 8;
    localparam int OFF  = $clog2(BPB);
    localparam int IDXW = MEM_DEPTH_LOG2;
    localparam int TOP  = OFF + IDXW;

    function automatic logic is_bad(input logic [ADDR_WIDTH-1:0] addr,
                                    input logic [2:0] size, input logic [1:0] burst);
        return (|(addr >> TOP)) || (size != 3'(OFF)) || burst[1];
    endfunction

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DRAIN} rstate_t;

    // ---------------- write side ----------------
    wstate_t             wstate_q;
    logic                awready_q, wready_q, bvalid_q, wfixed_q, wbad_q;
    logic [1:0]          bresp_q;
    logic [ID_WIDTH-1:0] wid_q;
    logic [IDXW-1:0]     widx_q;
    logic [7:0]          wlen_q, wcnt_q;
    logic                aw_hs, w_hs, b_hs, aw_bad, w_last_beat;

    assign aw_hs       = nap.awvalid && awready_q;
    assign w_hs        = nap.wvalid && wready_q;
    assign b_hs        = bvalid_q && nap.bready;
    assign aw_bad      = is_bad(nap.awaddr, nap.awsize, nap.awburst);
    assign w_last_beat = (wcnt_q == wlen_q);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            wid_q     <= '0;
            widx_q    <= '0;
            wlen_q    <= '0;
            wcnt_q    <= '0;
            wfixed_q  <= 1'b0;
            wbad_q    <= 1'b0;
        end else begin
            case (wstate_q)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_hs) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wid_q     <= nap.awid;
                        widx_q    <= nap.awaddr[TOP-1:OFF];
                        wlen_q    <= nap.awlen;
                        wcnt_q    <= '0;
                        wfixed_q  <= (nap.awburst == 2'b00);
                        wbad_q    <= aw_bad;
                        wstate_q  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wcnt_q <= wcnt_q + 8'd1;
                        if (!wfixed_q) widx_q <= widx_q + 1'b1;
                        // Beat count, not wlast, decides where the burst ends.
                        if (w_last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= wbad_q ? 2'b10 : 2'b00;
                            wstate_q <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (b_hs) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wstate_q  <= W_IDLE;
                    end
                end
                default: wstate_q <= W_IDLE;
            endcase
        end
    end

    assign nap.awready = awready_q;
    assign nap.wready  = wready_q;
    assign nap.bvalid  = bvalid_q;
    assign nap.bid     = wid_q;
    assign nap.bresp   = bresp_q;

    // ---------------- memory ----------------
    logic                  mem_we, rd_issue;
    logic [IDXW-1:0]       ridx_q;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    assign mem_we = w_hs && !wbad_q;

    // One byte-wide array per lane; read and write share a block so a
    // same-cycle collision returns the old contents.
    for (genvar gi = 0; gi < BPB; gi++) begin : g_lane
        logic [7:0] lane_mem [2**IDXW];
        logic [7:0] lane_rd_q;
        always_ff @(posedge i_clk) begin
            if (mem_we && nap.wstrb[gi]) lane_mem[widx_q] <= nap.wdata[gi*8 +: 8];
            if (rd_issue) lane_rd_q <= lane_mem[ridx_q];
        end
        assign mem_rd_data[gi*8 +: 8] = lane_rd_q;
    end

    // ---------------- read side ----------------
    rstate_t               rstate_q;
    logic                  arready_q, rfixed_q, rbad_q, rd_pend_q, rd_pend_last_q;
    logic [ID_WIDTH-1:0]   rid_q;
    logic [7:0]            rlen_q, rcnt_q;
    logic [DATA_WIDTH-1:0] buf_data_q [2];
    logic [1:0]            buf_resp_q [2];
    logic                  buf_last_q [2];
    logic                  buf_wp_q, buf_rp_q;
    logic [1:0]            buf_cnt_q;
    logic                  ar_hs, ar_bad, r_pop, r_last_hs;

    assign ar_hs     = nap.arvalid && arready_q;
    assign ar_bad    = is_bad(nap.araddr, nap.arsize, nap.arburst);
    assign r_pop     = (buf_cnt_q != 2'd0) && nap.rready;
    assign r_last_hs = r_pop && buf_last_q[buf_rp_q];
    // Only issue a read when the buffer is guaranteed a free slot for it.
    assign rd_issue  = (rstate_q == R_FETCH) &&
                       (({1'b0, buf_cnt_q} + {2'b00, rd_pend_q}) < (3'd2 + {2'b00, r_pop}));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rstate_q       <= R_IDLE;
            arready_q      <= 1'b0;
            rid_q          <= '0;
            ridx_q         <= '0;
            rlen_q         <= '0;
            rcnt_q         <= '0;
            rfixed_q       <= 1'b0;
            rbad_q         <= 1'b0;
            rd_pend_q      <= 1'b0;
            rd_pend_last_q <= 1'b0;
            buf_wp_q       <= 1'b0;
            buf_rp_q       <= 1'b0;
            buf_cnt_q      <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_data_q[i] <= '0;
                buf_resp_q[i] <= 2'b00;
                buf_last_q[i] <= 1'b0;
            end
        end else begin
            rd_pend_q      <= rd_issue;
            rd_pend_last_q <= (rcnt_q == rlen_q);
            if (rd_pend_q) begin
                buf_data_q[buf_wp_q] <= rbad_q ? '0 : mem_rd_data;
                buf_resp_q[buf_wp_q] <= rbad_q ? 2'b10 : 2'b00;
                buf_last_q[buf_wp_q] <= rd_pend_last_q;
                buf_wp_q             <= ~buf_wp_q;
            end
            if (r_pop) buf_rp_q <= ~buf_rp_q;
            buf_cnt_q <= buf_cnt_q + {1'b0, rd_pend_q} - {1'b0, r_pop};

            case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_hs) begin
                        arready_q <= 1'b0;
                        rid_q     <= nap.arid;
                        ridx_q    <= nap.araddr[TOP-1:OFF];
                        rlen_q    <= nap.arlen;
                        rcnt_q    <= '0;
                        rfixed_q  <= (nap.arburst == 2'b00);
                        rbad_q    <= ar_bad;
                        rstate_q  <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    if (rd_issue) begin
                        rcnt_q <= rcnt_q + 8'd1;
                        if (!rfixed_q) ridx_q <= ridx_q + 1'b1;
                        if (rcnt_q == rlen_q) rstate_q <= R_DRAIN;
                    end
                end
                R_DRAIN: begin
                    if (r_last_hs) begin
                        arready_q <= 1'b1;
                        rstate_q  <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign nap.arready = arready_q;
    assign nap.rvalid  = (buf_cnt_q != 2'd0);
    assign nap.rdata   = buf_data_q[buf_rp_q];
    assign nap.rresp   = buf_resp_q[buf_rp_q];
    assign nap.rlast   = buf_last_q[buf_rp_q];
    assign nap.rid     = rid_q;

    // ---------------- errors ----------------
    logic       err_valid_q;
    logic [2:0] err_info_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            err_valid_q <= 1'b0;
            err_info_q  <= 3'd0;
        end else begin
            err_valid_q <= 1'b0;
            if (ar_hs && ar_bad) begin
                err_valid_q <= 1'b1;
                err_info_q  <= 3'd3;
            end else if (aw_hs && aw_bad) begin
                err_valid_q <= 1'b1;
                err_info_q  <= 3'd1;
            end else if (w_hs && (nap.wlast != w_last_beat)) begin
                err_valid_q <= 1'b1;
                err_info_q  <= 3'd2;
            end
        end
    end

    assign o_error_valid = err_valid_q;
    assign o_error_info  = err_info_q;

`ifdef NAP_SLAVE_RESPONDER_STATS_EN
    logic [31:0] wr_bursts_q, rd_bursts_q;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_bursts_q <= '0;
            rd_bursts_q <= '0;
        end else begin
            if (b_hs)      wr_bursts_q <= wr_bursts_q + 32'd1;
            if (r_last_hs) rd_bursts_q <= rd_bursts_q + 32'd1;
        end
    end

    assign o_wr_bursts = wr_bursts_q;
    assign o_rd_bursts = rd_bursts_q;
`else
    assign o_wr_bursts = 32'd0;
    assign o_rd_bursts = 32'd0;
`endif
endmodule

// File: doc/nap_slave_responder.md
Name: nap_slave_responder

Overview:
- Fabric-side AXI4 slave responder sitting on the far end of a NAP AXI path.
- Accepts write and read bursts issued by a NoC master and stores the data in an internal simple-dual-port memory.
- Returns B and R responses with the matching ID.
- Acts as the terminating target for NoC traffic generators and for loopback tests.

Parameters:
- DATA_WIDTH, 256, AXI data width in bits; bytes per beat BPB = DATA_WIDTH/8.
- ADDR_WIDTH, 28, byte address width used from the interface.
- ID_WIDTH, 8, AXI ID width.
- MEM_DEPTH_LOG2, 9, log2 of the number of memory words (one word = one beat).

Ports:
- i_clk  in  1  single clock.
- i_reset  in  1  synchronous, active-high reset.
- nap  t_AXI4.slave  -  AXI4 slave side: aw*/w*/b*/ar*/r* channels; awaddr/araddr [ADDR_WIDTH-1:0]; wdata/rdata DATA_WIDTH; wstrb BPB; IDs ID_WIDTH.
- o_error_valid  out  1  one-cycle pulse when an error is detected.
- o_error_info  out  3  error code, valid with o_error_valid.
- o_wr_bursts  out  32  completed write burst count.
- o_rd_bursts  out  32  completed read burst count.

Behaviour:
- Reset: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=0, rlast=0, rdata=0, o_error_valid=0, o_error_info=0, counters=0, both FSMs in IDLE. Memory contents are not reset.
- Address decode:
  - word index = addr[log2(BPB)+MEM_DEPTH_LOG2-1 : log2(BPB)].
  - A burst is "bad" if any higher address bit is set, if size != log2(BPB), or if burst type is WRAP (2'b10) or reserved (2'b11).
  - FIXED bursts reuse the same index every beat. INCR bursts add 1 per beat, wrapping modulo depth.
- Write FSM:
  - W_IDLE: awready=1. On the AW handshake, latch id, index, len, burst and the bad flag, then go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the memory with byte enables = wstrb; writes are suppressed if the burst is bad. A beat counter runs from 0 to len.
  - On the beat where count==len, go to W_RESP. If wlast does not match (count==len), raise error code 3'd2 and still use the beat count.
  - W_RESP: bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if bad, otherwise 2'b00. Hold until bready, then go to W_IDLE.
- Read FSM:
  - R_IDLE: arready=1. On the AR handshake, latch id, index, len, burst and the bad flag, then go to R_FETCH.
  - The memory has 1-cycle registered read latency. A 2-entry output buffer allows back-to-back beats.
  - First rvalid appears exactly 2 cycles after the AR handshake.
  - With rready held high, beats arrive one per cycle.
  - rdata, rresp, rlast and rid stay stable while rvalid=1 and rready=0.
  - A bad burst returns rdata=0 and rresp=2'b10 on all len+1 beats.
  - rlast=1 on beat len only. After the rlast handshake, return to R_IDLE.
- Concurrency and hazards:
  - Read and write FSMs run independently.
  - A read and a write to the same word in the same cycle returns the old data (read-first).
- Errors:
  - Error codes: 3'd1 = bad write burst, 3'd2 = wlast mismatch, 3'd3 = bad read burst.
  - An error pulses at the AW/AR handshake (codes 1/3) or at the offending beat (code 2).
  - If two errors occur in the same cycle, the read error takes priority.
- Reset mid-burst: all FSMs return to IDLE, all valids drop in the same cycle, and in-flight bursts are abandoned with no response.

Optional Feature:
- Macro NAP_SLAVE_RESPONDER_STATS_EN.
- Defined:
  - o_wr_bursts increments on each B handshake; o_rd_bursts increments on each rlast handshake.
  - Both are 32-bit counters that wrap from 0xFFFFFFFF to 0 and are cleared by i_reset.
- Undefined: both outputs are tied to 0 and no counter logic is built.

Test Plan:
- Write INCR, addr 0x40, len 3, awid 0x12, wstrb all ones, data 0xA0..0xA3 -> bvalid with bid=0x12 and bresp=0. Then read addr 0x40, len 3, arid 0x34 -> rdata 0xA0..0xA3, rid=0x34, rlast on the 4th beat, first rvalid 2 cycles after AR.
- Write a single beat with wstrb=0x0000000F over a word preloaded with all-ones, new data 0 -> readback shows bytes 0..3 = 0x00 and bytes 4..31 = 0xFF.
- Read len 7 with rready toggling 1,0,0,1,... -> no beat lost or duplicated, data stable while stalled, 8 beats total.
- Write to awaddr 0x0004000 (above depth) -> bresp=2'b10, o_error_valid pulse with info=1, memory unchanged. Read with arburst=WRAP -> 4 beats of rdata=0, rresp=2'b10, info=3.
- Write len 3 with wlast asserted on beat 1 -> info=2 pulse, bvalid only after beat 3. Assert i_reset during the beat-2 transfer of a read -> rvalid=0 on the next cycle, and a new AR is accepted after reset.
- With NAP_SLAVE_RESPONDER_STATS_EN: 5 writes and 3 reads -> o_wr_bursts=5, o_rd_bursts=3. Without the macro -> both stay 0.
